// File: rtl/memory.sv
// Single-port synchronous RAM behind a valid/ready request interface.
// Each accepted request performs one read or write, then answers with a one-cycle ready pulse.
module memory #(
    parameter int MEMORY_WIDTH  = 8,
    parameter int MEMORY_DEPTH  = 16,
    parameter int ADDRESS_WIDTH = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic                     wr_rd_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [MEMORY_WIDTH-1:0]  wdata_i,
    output logic                     ready_o,
    output logic [MEMORY_WIDTH-1:0]  rdata_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // One extra bit so that a power-of-2 depth compares without overflowing the limit.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

    state_e                  state_q, state_d;
    logic [MEMORY_WIDTH-1:0] rdata_q, rdata_d;
    logic                    accept;
    logic                    in_range;

    // Kept as a flat array so memory-image load/dump and hierarchical access reach it directly.
    logic [MEMORY_WIDTH-1:0] mem [0:MEMORY_DEPTH-1];

    assign in_range = ({1'b0, addr_i} < DEPTH_LIMIT);

    // NOTE: every variable gets its default before the case, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    state_d = RESP;
                    if (!wr_rd_i) begin
                        rdata_d = in_range ? mem[addr_i] : '0;
                    end
                end
            end
            RESP: begin
                // valid_i is deliberately ignored here so a master may hold it while sampling ready_o.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: clearing the array on reset rules out a RAM macro and builds it from flops;
    // that is the intended trade for a guaranteed all-zero, X-free image after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && wr_rd_i && in_range) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign ready_o = (state_q == RESP);
    assign rdata_o = rdata_q;

    ready_single_pulse: assert property (@(posedge clk_i) disable iff (!rst_i)
        ready_o |=> !ready_o);

    rdata_known: assert property (@(posedge clk_i) disable iff (!rst_i)
        !$isunknown(rdata_o));

endmodule

// File: tb/tb_memory.sv
// Scoreboard-driven bench for the memory block: reset, frontdoor/backdoor paths,
// handshake spacing, address wrap and a random write/read pass.
module tb_memory;

    logic       clk_i;
    logic       rst_i;
    logic       valid_i;
    logic       wr_rd_i;
    logic [3:0] addr_i;
    logic [7:0] wdata_i;
    logic       ready_o;
    logic [7:0] rdata_o;

    int total;
    int bad;

    logic [7:0] model [16];
    logic [7:0] exp_q [$];

    memory #(
        .MEMORY_WIDTH (8),
        .MEMORY_DEPTH (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .wr_rd_i (wr_rd_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ready_o (ready_o),
        .rdata_o (rdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
        $fatal(1, "watchdog");
    end

    // One complete request; reads push their expected word and pop it when ready_o arrives.
    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int         n;
        logic [7:0] exp;
        @(negedge clk_i);
        valid_i = 1'b1;
        wr_rd_i = wr;
        addr_i  = a;
        wdata_i = d;
        if (wr) model[a] = d;
        else    exp_q.push_back(model[a]);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 8);
        valid_i = 1'b0;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL req_ready addr=%0d wr=%0b: ready_o=%b required 1", a, wr, ready_o);
            if (!wr) void'(exp_q.pop_front());
        end else if (!wr) begin
            exp = exp_q.pop_front();
            total++;
            if (rdata_o !== exp) begin
                bad++;
                $display("FAIL read_data addr=%0d: rdata_o=%h required %h", a, rdata_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        wr_rd_i = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        foreach (model[i]) model[i] = 8'h00;
        #1;
        total++;
        if (ready_o !== 1'b0 || rdata_o !== 8'h00) begin
            bad++;
            $display("FAIL por_outputs: ready_o=%b rdata_o=%h required 0/00", ready_o, rdata_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        issue(1'b1, 4'd2, 8'h77);
        issue(1'b1, 4'd5, 8'hEE);
        issue(1'b0, 4'd2, 8'h00);

        // Reset lands while a read is in its response cycle.
        @(negedge clk_i);
        valid_i = 1'b1;
        wr_rd_i = 1'b0;
        addr_i  = 4'd5;
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || rdata_o !== 8'h00) begin
            bad++;
            $display("FAIL midstream_reset: ready_o=%b rdata_o=%h required 0/00", ready_o, rdata_o);
        end
        // A write held during reset must not land.
        wr_rd_i = 1'b1;
        addr_i  = 4'd9;
        wdata_i = 8'h42;
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        foreach (model[i]) model[i] = 8'h00;
        exp_q.delete();
        for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), 8'h00);
    endtask

    task automatic test_frontdoor();
        for (int k = 0; k < 16; k++) issue(1'b1, 4'(k), 8'hA0 + 8'(k));
        for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), 8'h00);
        // A write must leave the last read word on rdata_o.
        issue(1'b1, 4'd0, 8'h11);
        total++;
        if (rdata_o !== 8'hAF) begin
            bad++;
            $display("FAIL rdata_hold: rdata_o=%h required af", rdata_o);
        end
    endtask

    task automatic test_backdoor_load();
        logic [7:0] image [16];
        for (int k = 0; k < 16; k++) image[k] = 8'(k * 37 + 27);
        @(negedge clk_i);
        for (int k = 0; k < 16; k++) begin
            dut.mem[k] <= image[k];
            model[k] = image[k];
        end
        #1;
        for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), 8'h00);
    endtask

    task automatic test_backdoor_dump();
        string s3;
        string s15;
        issue(1'b1, 4'd3, 8'h5A);
        issue(1'b1, 4'd15, 8'hC3);
        s3  = $sformatf("%b", dut.mem[3]);
        s15 = $sformatf("%b", dut.mem[15]);
        total++;
        if (s3 != "01011010") begin
            bad++;
            $display("FAIL dump_addr3: mem[3]=%s required 01011010", s3);
        end
        total++;
        if (s15 != "11000011") begin
            bad++;
            $display("FAIL dump_addr15: mem[15]=%s required 11000011", s15);
        end
    endtask

    task automatic test_handshake_wrap();
        logic [4:0] wide_addr;
        logic       exp_ready;
        @(negedge clk_i);
        valid_i = 1'b1;
        wr_rd_i = 1'b0;
        addr_i  = 4'd1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if (k == 8) valid_i = 1'b0;
            exp_ready = (k % 2 == 1);
            total++;
            if (ready_o !== exp_ready) begin
                bad++;
                $display("FAIL held_valid cycle=%0d: ready_o=%b required %b", k, ready_o, exp_ready);
            end
            if (exp_ready && ready_o) begin
                total++;
                if (rdata_o !== model[1]) begin
                    bad++;
                    $display("FAIL held_valid_data cycle=%0d: rdata_o=%h required %h", k, rdata_o, model[1]);
                end
            end
        end
        wide_addr = 5'd16;
        issue(1'b1, wide_addr[3:0], 8'h99);
        issue(1'b0, 4'd0, 8'h00);
        total++;
        if (rdata_o !== 8'h99) begin
            bad++;
            $display("FAIL addr_wrap: rdata_o=%h required 99", rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 4'd7, 8'h3E);
        issue(1'b0, 4'd7, 8'h00);
        issue(1'b1, 4'd7, 8'hD4);
        issue(1'b0, 4'd7, 8'h00);
    endtask

    task automatic test_random();
        logic [3:0] addrs [17];
        for (int k = 0; k < 17; k++) begin
            addrs[k] = 4'($urandom_range(0, 15));
            issue(1'b1, addrs[k], 8'($urandom_range(0, 255)));
        end
        for (int k = 0; k < 17; k++) issue(1'b0, addrs[k], 8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_frontdoor();
        test_backdoor_load();
        test_backdoor_dump();
        test_handshake_wrap();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
